// File: rtl/manchester_frame_encoder.sv
// Manchester line encoder: valid/ready word input, optional preamble, serialised
// Manchester data with back-to-back frame chaining and a fixed idle gap per frame.
module manchester_frame_encoder #(
    parameter int DATA_W        = 8,
    parameter int HALF_BIT_DIV  = 4,
    parameter int PREAMBLE_BITS = 8,
    parameter int GAP_BITS      = 2,
    parameter bit POLARITY      = 1'b0,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit IDLE_LEVEL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W   = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
    localparam int MAX_DP  = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
    localparam int BIT_MAX = (MAX_DP > GAP_BITS) ? MAX_DP : GAP_BITS;
    localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_BIT_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              half_q, half_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              init_q, init_d;
    logic              dout_q, dout_d;
    logic              dout_en_q, dout_en_d;

    logic strobe;
    logic last_half;
    logic data_window;
    logic handshake;
    logic cur_bit;

    function automatic logic encode(input logic b, input logic h);
        if (POLARITY)
            return h ? ~b : b;
        else
            return h ? b : ~b;
    endfunction

    assign strobe      = (div_cnt_q == DIV_LAST);
    assign last_half   = strobe && half_q;
    assign data_window = (state_q == ST_DATA) && last_half && (bit_cnt_q == DATA_LAST);
    assign s_ready     = ((state_q == ST_IDLE) && init_q) || data_window;
    assign handshake   = s_valid && s_ready;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_GAP) && last_half && (bit_cnt_q == GAP_LAST);
    assign dout        = dout_q;
    assign dout_en     = dout_en_q;

    // Counters and state describe the half-bit that dout_q will carry next cycle,
    // so the line register is computed from the next-state values.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
        half_d    = strobe ? ~half_q : half_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        init_d    = 1'b1;
        cur_bit   = 1'b0;
        dout_d    = IDLE_LEVEL;
        dout_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                half_d    = 1'b0;
                bit_cnt_d = '0;
                if (handshake) begin
                    shift_d = s_data;
                    state_d = (PREAMBLE_BITS > 0) ? ST_PREAMBLE : ST_DATA;
                end
            end
            ST_PREAMBLE: begin
                if (last_half) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (last_half) begin
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (handshake)
                            shift_d = s_data;
                        else
                            state_d = ST_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (last_half) begin
                    if (bit_cnt_q == GAP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cur_bit = MSB_FIRST ? shift_d[DATA_W-1] : shift_d[0];

        case (state_d)
            ST_PREAMBLE: begin
                dout_d    = encode(1'b1, half_d);
                dout_en_d = 1'b1;
            end
            ST_DATA: begin
                dout_d    = encode(cur_bit, half_d);
                dout_en_d = 1'b1;
            end
            default: begin
                dout_d    = IDLE_LEVEL;
                dout_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            half_q    <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            init_q    <= 1'b0;
            dout_q    <= IDLE_LEVEL;
            dout_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            init_q    <= init_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
        end
    end

endmodule

// File: tb/tb_manchester_frame_encoder.sv
// Directed bench: two encoder configurations sharing clock and reset, one task per scenario.
module tb_manchester_frame_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready, dout, dout_en, busy, frame_done;
    logic [7:0] s_data_b;
    logic       s_valid_b;
    logic       s_ready_b, dout_b, dout_en_b, busy_b, frame_done_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    manchester_frame_encoder #(
        .DATA_W(8), .HALF_BIT_DIV(2), .PREAMBLE_BITS(4), .GAP_BITS(2),
        .POLARITY(1'b0), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dout(dout), .dout_en(dout_en), .busy(busy),
        .frame_done(frame_done)
    );

    manchester_frame_encoder #(
        .DATA_W(8), .HALF_BIT_DIV(2), .PREAMBLE_BITS(0), .GAP_BITS(2),
        .POLARITY(1'b1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b),
        .s_ready(s_ready_b), .dout(dout_b), .dout_en(dout_en_b), .busy(busy_b),
        .frame_done(frame_done_b)
    );

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_valid_b = 1'b0; s_data_b = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 1'b0)       begin errors++; $display("[TB] FAIL reset_dout: got %b expected 0", dout); end
        checks++; if (dout_en !== 1'b0)    begin errors++; $display("[TB] FAIL reset_dout_en: got %b expected 0", dout_en); end
        checks++; if (s_ready !== 1'b0)    begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (dout_en_b !== 1'b0)  begin errors++; $display("[TB] FAIL reset_dout_en_b: got %b expected 0", dout_en_b); end
        rst_n = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_no_init: got %b expected 0", s_ready); end
        @(negedge clk);
        checks++; if (s_ready !== 1'b1)   begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", s_ready); end
        checks++; if (s_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL release_ready_b: got %b expected 1", s_ready_b); end
    endtask

    task automatic test_single_frame();
        logic [23:0] exp_half;
        logic [47:0] exp_cyc, obs_dout, obs_en, obs_rdy;
        logic [8:0]  obs_fd, obs_busy, obs_line;
        exp_half = 24'b01010101_0110011010011001;
        for (int c = 0; c < 48; c++) exp_cyc[47-c] = exp_half[23-c/2];
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_idle: got %b expected 1", s_ready); end
        s_data = 8'hA5; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'h00;
        for (int c = 0; c < 48; c++) begin
            obs_dout[47-c] = dout; obs_en[47-c] = dout_en; obs_rdy[47-c] = s_ready;
            @(negedge clk);
        end
        for (int c = 0; c < 9; c++) begin
            obs_fd[8-c] = frame_done; obs_busy[8-c] = busy; obs_line[8-c] = dout_en | dout;
            @(negedge clk);
        end
        checks++; if (obs_dout !== exp_cyc)  begin errors++; $display("[TB] FAIL single_dout: got %h expected %h", obs_dout, exp_cyc); end
        checks++; if (obs_en !== {48{1'b1}}) begin errors++; $display("[TB] FAIL single_dout_en: got %h expected ffffffffffff", obs_en); end
        checks++; if (obs_rdy !== 48'h1)     begin errors++; $display("[TB] FAIL single_ready_window: got %h expected 000000000001", obs_rdy); end
        checks++; if (obs_fd !== 9'b000000010)   begin errors++; $display("[TB] FAIL single_frame_done: got %b expected 000000010", obs_fd); end
        checks++; if (obs_busy !== 9'b111111110) begin errors++; $display("[TB] FAIL single_busy: got %b expected 111111110", obs_busy); end
        checks++; if (obs_line !== 9'b0)         begin errors++; $display("[TB] FAIL single_gap_line: got %b expected 000000000", obs_line); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_after: got %b expected 1", s_ready); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_half;
        logic [79:0] exp_cyc, obs_dout, obs_en, obs_rdy;
        logic [8:0]  obs_fd, obs_busy;
        int fd_count;
        fd_count = 0;
        exp_half = {8'b01010101, 16'b1010101010101010, 16'b0101010101010101};
        for (int c = 0; c < 80; c++) exp_cyc[79-c] = exp_half[39-c/2];
        s_data = 8'h00; s_valid = 1'b1;
        @(negedge clk);
        s_data = 8'hFF;
        for (int c = 0; c < 80; c++) begin
            obs_dout[79-c] = dout; obs_en[79-c] = dout_en; obs_rdy[79-c] = s_ready;
            if (frame_done) fd_count++;
            if (c == 48) s_valid = 1'b0;
            @(negedge clk);
        end
        for (int c = 0; c < 9; c++) begin
            obs_fd[8-c] = frame_done; obs_busy[8-c] = busy;
            if (frame_done) fd_count++;
            @(negedge clk);
        end
        checks++; if (obs_dout !== exp_cyc)  begin errors++; $display("[TB] FAIL b2b_dout: got %h expected %h", obs_dout, exp_cyc); end
        checks++; if (obs_en !== {80{1'b1}}) begin errors++; $display("[TB] FAIL b2b_dout_en: got %h expected all ones", obs_en); end
        checks++; if (obs_rdy !== 80'h00000000000100000001) begin errors++; $display("[TB] FAIL b2b_ready: got %h expected 00000000000100000001", obs_rdy); end
        checks++; if (obs_fd !== 9'b000000010)   begin errors++; $display("[TB] FAIL b2b_frame_done: got %b expected 000000010", obs_fd); end
        checks++; if (obs_busy !== 9'b111111110) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 111111110", obs_busy); end
        checks++; if (fd_count != 1) begin errors++; $display("[TB] FAIL b2b_frame_done_count: got %0d expected 1", fd_count); end
    endtask

    task automatic test_polarity_lsb();
        logic [15:0] exp_half;
        logic [31:0] exp_cyc, obs_dout, obs_en, obs_rdy;
        logic [8:0]  obs_fd;
        exp_half = 16'b1001010101010101;
        for (int c = 0; c < 32; c++) exp_cyc[31-c] = exp_half[15-c/2];
        checks++; if (s_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL pol_ready_idle: got %b expected 1", s_ready_b); end
        s_data_b = 8'h01; s_valid_b = 1'b1;
        @(negedge clk);
        s_valid_b = 1'b0; s_data_b = 8'hFE;
        for (int c = 0; c < 32; c++) begin
            obs_dout[31-c] = dout_b; obs_en[31-c] = dout_en_b; obs_rdy[31-c] = s_ready_b;
            @(negedge clk);
        end
        for (int c = 0; c < 9; c++) begin
            obs_fd[8-c] = frame_done_b;
            @(negedge clk);
        end
        checks++; if (obs_dout !== exp_cyc)      begin errors++; $display("[TB] FAIL pol_dout: got %h expected %h", obs_dout, exp_cyc); end
        checks++; if (obs_en !== 32'hFFFFFFFF)   begin errors++; $display("[TB] FAIL pol_dout_en: got %h expected ffffffff", obs_en); end
        checks++; if (obs_rdy !== 32'h1)         begin errors++; $display("[TB] FAIL pol_ready_window: got %h expected 00000001", obs_rdy); end
        checks++; if (obs_fd !== 9'b000000010)   begin errors++; $display("[TB] FAIL pol_frame_done: got %b expected 000000010", obs_fd); end
        checks++; if (busy_b !== 1'b0)          begin errors++; $display("[TB] FAIL pol_busy_after: got %b expected 0", busy_b); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] obs_dout, obs_en;
        int fd_count;
        fd_count = 0;
        s_data = 8'h5A; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (dout !== 1'b1)    begin errors++; $display("[TB] FAIL midrst_dout_before: got %b expected 1", dout); end
        checks++; if (dout_en !== 1'b1) begin errors++; $display("[TB] FAIL midrst_en_before: got %b expected 1", dout_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_dout: got %b expected 0", dout); end
        checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dout_en: got %b expected 0", dout_en); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0", s_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready_after: got %b expected 1", s_ready); end
        s_data = 8'hC3; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            obs_dout[15-c] = dout; obs_en[15-c] = dout_en;
            @(negedge clk);
        end
        for (int c = 16; c < 56; c++) begin
            if (frame_done) fd_count++;
            @(negedge clk);
        end
        checks++; if (obs_dout !== 16'b0011001100110011) begin errors++; $display("[TB] FAIL midrst_preamble: got %b expected 0011001100110011", obs_dout); end
        checks++; if (obs_en !== 16'hFFFF) begin errors++; $display("[TB] FAIL midrst_preamble_en: got %h expected ffff", obs_en); end
        checks++; if (fd_count != 1)       begin errors++; $display("[TB] FAIL midrst_frame_done: got %0d expected 1", fd_count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_valid_while_busy();
        logic [55:0] obs_en, obs_rdy;
        logic [23:0] exp_half;
        logic [47:0] exp_cyc, obs_dout;
        exp_half = 24'b01010101_1010010101011010;
        for (int c = 0; c < 48; c++) exp_cyc[47-c] = exp_half[23-c/2];
        s_data = 8'h11; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 0; c < 56; c++) begin
            obs_en[55-c] = dout_en; obs_rdy[55-c] = s_ready;
            if (c == 2)  begin s_valid = 1'b1; s_data = 8'h3C; end
            if (c == 45) s_valid = 1'b0;
            if (c == 48) s_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (obs_en !== {{48{1'b1}}, 8'h00}) begin errors++; $display("[TB] FAIL vbusy_first_en: got %h expected ffffffffffff00", obs_en); end
        checks++; if (obs_rdy !== 56'h100) begin errors++; $display("[TB] FAIL vbusy_ready: got %h expected 00000000000100", obs_rdy); end
        checks++; if (s_ready !== 1'b1)    begin errors++; $display("[TB] FAIL vbusy_ready_idle: got %b expected 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'h00;
        for (int c = 0; c < 48; c++) begin
            obs_dout[47-c] = dout;
            @(negedge clk);
        end
        checks++; if (obs_dout !== exp_cyc) begin errors++; $display("[TB] FAIL vbusy_dout: got %h expected %h", obs_dout, exp_cyc); end
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL vbusy_busy_end: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_polarity_lsb();
        test_reset_mid_frame();
        test_valid_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
